// File: rtl/avmm_stat_bank_slave_if.sv
// Avalon-MM slave bus bundle between the HPS lightweight bridge and the stat bank.
// The spec-defined slave_* port names are kept as the interface members.
interface avmm_stat_bank_slave_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 10
) ();
  logic [ADDR_W-1:0]   slave_address;
  logic                slave_read;
  logic                slave_write;
  logic [DATA_W/8-1:0] slave_byteenable;
  logic [DATA_W-1:0]   slave_writedata;
  logic [DATA_W-1:0]   slave_readdata;
  logic                slave_readdatavalid;
  logic                slave_waitrequest;

  modport slave (
    input  slave_address, slave_read, slave_write, slave_byteenable, slave_writedata,
    output slave_readdata, slave_readdatavalid, slave_waitrequest
  );

  modport master (
    output slave_address, slave_read, slave_write, slave_byteenable, slave_writedata,
    input  slave_readdata, slave_readdatavalid, slave_waitrequest
  );
endinterface

// File: rtl/avmm_stat_bank_slave.sv
// Avalon-MM slave exposing a coherent snapshot bank of the analysis result channels,
// a back-pressured command channel, and a CTRL/STATUS word with a snapshot counter.
module avmm_stat_bank_slave #(
  parameter int DATA_W   = 64,
  parameter int N_CH     = 66,
  parameter int ADDR_W   = 10,
  parameter int ADDR_LSB = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  avmm_stat_bank_slave_if.slave        bus,
  input  logic [N_CH-1:0][DATA_W-1:0]  datain,
  output logic [DATA_W-1:0]            cmd_data,
  output logic                         cmd_valid,
  input  logic                         cmd_ready
);

  localparam int BE_W   = DATA_W / 8;
  localparam int WORD_W = ADDR_W - ADDR_LSB;
  localparam int IDX_W  = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [WORD_W-1:0] W_CMD       = WORD_W'(0);
  localparam logic [WORD_W-1:0] W_CTRL      = WORD_W'(1);
  localparam logic [WORD_W-1:0] W_SHD_FIRST = WORD_W'(2);
  localparam logic [WORD_W-1:0] W_SHD_LAST  = WORD_W'(N_CH + 1);

  // Zero every byte lane whose enable is low.
  function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0]   be,
                                                   input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < BE_W; i++) begin
      m[i*8 +: 8] = be[i] ? d[i*8 +: 8] : 8'h00;
    end
    return m;
  endfunction

  logic [DATA_W-1:0] readdata_r;
  logic              readdatavalid_r;
  logic [DATA_W-1:0] cmd_data_r;
  logic              cmd_valid_r;
  logic [DATA_W-1:0] last_cmd_r;
  logic [31:0]       snap_cnt_r;
  logic [DATA_W-1:0] shadow_r [N_CH];

  logic [WORD_W-1:0]   word_s;
  logic [WORD_W-1:0]   shd_off_s;
  logic                is_cmd_s;
  logic                is_ctrl_s;
  logic                is_shd_s;
  logic                cmd_wr_s;
  logic                ctrl_wr_s;
  logic                snap_s;
  logic                clr_s;
  logic [DATA_W-1:0]   wr_masked_s;
  logic [DATA_W-1:0]   rd_data_s;
  logic                unused_addr_s;

  assign word_s        = bus.slave_address[ADDR_W-1:ADDR_LSB];
  assign unused_addr_s = ^bus.slave_address[ADDR_LSB-1:0];
  assign shd_off_s     = word_s - W_SHD_FIRST;

  assign is_cmd_s  = (word_s == W_CMD);
  assign is_ctrl_s = (word_s == W_CTRL);
  assign is_shd_s  = (word_s >= W_SHD_FIRST) && (word_s <= W_SHD_LAST);

  assign wr_masked_s = lane_mask(bus.slave_byteenable, bus.slave_writedata);

  // A CMD write may only land when the output slot is empty or draining this cycle.
  assign cmd_wr_s  = bus.slave_write && is_cmd_s && (!cmd_valid_r || cmd_ready);
  assign ctrl_wr_s = bus.slave_write && is_ctrl_s && bus.slave_byteenable[0];
  assign snap_s    = ctrl_wr_s && bus.slave_writedata[0];
  assign clr_s     = ctrl_wr_s && bus.slave_writedata[1];

  assign bus.slave_waitrequest   = bus.slave_write && is_cmd_s && cmd_valid_r && !cmd_ready;
  assign bus.slave_readdata      = readdata_r;
  assign bus.slave_readdatavalid = readdatavalid_r;
  assign cmd_data                = cmd_data_r;
  assign cmd_valid               = cmd_valid_r;

  // Read mux over the word map, sampling pre-edge state so SNAP/CLR are not visible yet.
  always_comb begin
    rd_data_s = '0;
    if (is_cmd_s) begin
      rd_data_s = last_cmd_r;
    end else if (is_ctrl_s) begin
      rd_data_s = {{(DATA_W-33){1'b0}}, cmd_valid_r, snap_cnt_r};
    end else if (is_shd_s) begin
      rd_data_s = shadow_r[shd_off_s[IDX_W-1:0]];
    end else begin
      rd_data_s = '0;
    end
  end

  // Registered read response with one-cycle latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata_r      <= '0;
      readdatavalid_r <= 1'b0;
    end else begin
      readdatavalid_r <= bus.slave_read;
      if (bus.slave_read) begin
        readdata_r <= rd_data_s;
      end else begin
        readdata_r <= readdata_r;
      end
    end
  end

  // Command slot: load on accepted write, drain on handshake, hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_data_r  <= '0;
      cmd_valid_r <= 1'b0;
      last_cmd_r  <= '0;
    end else if (cmd_wr_s) begin
      cmd_data_r  <= wr_masked_s;
      cmd_valid_r <= 1'b1;
      last_cmd_r  <= wr_masked_s;
    end else if (cmd_ready) begin
      cmd_valid_r <= 1'b0;
    end else begin
      cmd_valid_r <= cmd_valid_r;
    end
  end

  // Snapshot bank and counter; CLR overrides the increment but not the capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_cnt_r <= 32'h0000_0000;
      for (int i = 0; i < N_CH; i++) begin
        shadow_r[i] <= '0;
      end
    end else begin
      if (clr_s) begin
        snap_cnt_r <= 32'h0000_0000;
      end else if (snap_s) begin
        snap_cnt_r <= snap_cnt_r + 32'h0000_0001;
      end else begin
        snap_cnt_r <= snap_cnt_r;
      end
      if (snap_s) begin
        for (int i = 0; i < N_CH; i++) begin
          shadow_r[i] <= datain[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_avmm_stat_bank_slave.sv
// Directed, table-driven bench for avmm_stat_bank_slave with hand-written
// sequences for counter wrap, read-data hold and mid-operation reset.
module tb_avmm_stat_bank_slave;

  localparam int DATA_W = 64;
  localparam int N_CH   = 66;
  localparam int ADDR_W = 10;

  logic clk = 1'b0;
  logic reset;
  logic [N_CH-1:0][DATA_W-1:0] datain;
  logic [DATA_W-1:0] cmd_data;
  logic              cmd_valid;
  logic              cmd_ready;

  int n_vec = 0;
  int n_bad = 0;

  avmm_stat_bank_slave_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  avmm_stat_bank_slave #(.DATA_W(DATA_W), .N_CH(N_CH), .ADDR_W(ADDR_W), .ADDR_LSB(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .datain    (datain),
    .cmd_data  (cmd_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [9:0]  addr;
    logic [7:0]  be;
    logic [63:0] wd;
    logic        rdy;
    logic        upd;
    logic [63:0] d5;
    logic        ew;
    logic        erv;
    logic [63:0] erd;
    logic        ecv;
    logic [63:0] ecd;
  } vec_t;

  vec_t vt [$];

  function automatic vec_t mk(input logic wr, input logic rd, input logic [9:0] a,
                              input logic [7:0] be, input logic [63:0] wd, input logic rdy,
                              input logic upd, input logic [63:0] d5, input logic ew,
                              input logic erv, input logic [63:0] erd, input logic ecv,
                              input logic [63:0] ecd);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = a; v.be = be; v.wd = wd; v.rdy = rdy;
    v.upd = upd; v.d5 = d5; v.ew = ew; v.erv = erv; v.erd = erd; v.ecv = ecv; v.ecd = ecd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [9:0] a,
                       input logic [7:0] be, input logic [63:0] wd, input logic rdy);
    bus.slave_write      = wr;
    bus.slave_read       = rd;
    bus.slave_address    = a;
    bus.slave_byteenable = be;
    bus.slave_writedata  = wd;
    cmd_ready            = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  localparam logic [63:0] A5  = 64'hA5A5_0000_1234_5678;
  localparam logic [63:0] CD1 = 64'h0000_0000_5566_7788;
  localparam logic [63:0] CD2 = 64'hAABB_CCDD_0000_0000;
  localparam logic [63:0] CD3 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] CD4 = 64'hFEED_FACE_CAFE_F00D;
  localparam logic [63:0] D1  = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2  = 64'h2222_2222_2222_2222;
  localparam logic [63:0] D3  = 64'h3333_3333_3333_3333;
  localparam logic [63:0] D4  = 64'h4444_4444_4444_4444;
  localparam logic [63:0] Z   = 64'h0;

  initial begin
    for (int i = 0; i < N_CH; i++) begin
      datain[i] = {16'hC0DE, 16'(i), 16'h5A5A, 16'(i)};
    end
    datain[5] = A5;
    drive(1'b0, 1'b1, 10'h010, 8'h00, Z, 1'b0);
    reset = 1'b1;

    // wr rd addr be wd rdy | upd d5 | ew erv erd ecv ecd
    vt.push_back(mk(0, 1, 10'h010, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, Z));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, Z));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h1, 0, 0, Z, 0, 0, Z, 0, Z));
    vt.push_back(mk(0, 1, 10'h038, 8'h00, Z, 0, 1, D1, 0, 1, A5, 0, Z));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h1, 0, Z));
    vt.push_back(mk(0, 1, 10'h018, 8'h00, Z, 0, 0, Z, 0, 1, 64'hC0DE_0001_5A5A_0001, 0, Z));
    vt.push_back(mk(1, 0, 10'h000, 8'h0F, 64'h1122_3344_5566_7788, 0, 0, Z, 0, 0, Z, 1, CD1));
    vt.push_back(mk(0, 1, 10'h000, 8'h00, Z, 0, 0, Z, 0, 1, CD1, 1, CD1));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h0000_0001_0000_0001, 1, CD1));
    vt.push_back(mk(1, 0, 10'h000, 8'hF0, 64'hAABB_CCDD_EEFF_0011, 0, 0, Z, 1, 0, Z, 1, CD1));
    vt.push_back(mk(1, 0, 10'h000, 8'hF0, 64'hAABB_CCDD_EEFF_0011, 0, 0, Z, 1, 0, Z, 1, CD1));
    vt.push_back(mk(1, 0, 10'h000, 8'hF0, 64'hAABB_CCDD_EEFF_0011, 1, 0, Z, 0, 0, Z, 1, CD2));
    vt.push_back(mk(0, 0, 10'h000, 8'h00, Z, 1, 0, Z, 0, 0, Z, 0, CD2));
    vt.push_back(mk(0, 1, 10'h000, 8'h00, Z, 1, 0, Z, 0, 1, CD2, 0, CD2));
    vt.push_back(mk(1, 0, 10'h000, 8'hFF, CD3, 0, 0, Z, 0, 0, Z, 1, CD3));
    vt.push_back(mk(0, 0, 10'h000, 8'h00, Z, 0, 0, Z, 0, 0, Z, 1, CD3));
    vt.push_back(mk(0, 0, 10'h000, 8'h00, Z, 1, 0, Z, 0, 0, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h1, 0, 1, D1, 0, 0, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h1, 0, 0, Z, 0, 0, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h1, 0, 0, Z, 0, 0, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h4, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h3, 0, 1, D2, 0, 0, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h038, 8'h00, Z, 0, 0, Z, 0, 1, D2, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h02, 64'h1, 0, 1, D3, 0, 0, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h038, 8'h00, Z, 0, 0, Z, 0, 1, D2, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h1, 0, 0, Z, 0, 0, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, 64'h2, 0, 1, D4, 0, 0, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h038, 8'h00, Z, 0, 0, Z, 0, 1, D3, 0, CD3));
    vt.push_back(mk(1, 1, 10'h008, 8'h01, 64'h1, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h1, 0, CD3));
    vt.push_back(mk(0, 1, 10'h220, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h220, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, Z, 0, 0, Z, 0, CD3));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h1, 0, CD3));
    vt.push_back(mk(0, 1, 10'h038, 8'h00, Z, 0, 0, Z, 0, 1, D4, 0, CD3));
    vt.push_back(mk(0, 1, 10'h000, 8'h00, Z, 0, 0, Z, 0, 1, CD3, 0, CD3));
    vt.push_back(mk(0, 1, 10'h218, 8'h00, Z, 0, 0, Z, 0, 1, 64'hC0DE_0041_5A5A_0041, 0, CD3));
    vt.push_back(mk(0, 1, 10'h3F8, 8'h00, Z, 0, 0, Z, 0, 1, Z, 0, CD3));
    vt.push_back(mk(1, 0, 10'h000, 8'hFF, CD4, 0, 0, Z, 0, 0, Z, 1, CD4));
    vt.push_back(mk(1, 0, 10'h008, 8'h01, Z, 0, 0, Z, 0, 0, Z, 1, CD4));
    vt.push_back(mk(0, 1, 10'h008, 8'h00, Z, 0, 0, Z, 0, 1, 64'h0000_0001_0000_0001, 1, CD4));
    vt.push_back(mk(0, 1, 10'h000, 8'h00, Z, 0, 0, Z, 0, 1, CD4, 1, CD4));

    // Reset with a read pending: no response, all outputs cleared.
    cycle();
    cycle();
    chk("reset rvalid", {63'h0, bus.slave_readdatavalid}, Z);
    chk("reset rdata", bus.slave_readdata, Z);
    chk("reset cvalid", {63'h0, cmd_valid}, Z);
    chk("reset cdata", cmd_data, Z);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vt.size(); i++) begin
      @(negedge clk);
      if (vt[i].upd) datain[5] = vt[i].d5;
      drive(vt[i].wr, vt[i].rd, vt[i].addr, vt[i].be, vt[i].wd, vt[i].rdy);
      #1;
      chk($sformatf("v%0d waitrequest", i), {63'h0, bus.slave_waitrequest}, {63'h0, vt[i].ew});
      cycle();
      chk($sformatf("v%0d rvalid", i), {63'h0, bus.slave_readdatavalid}, {63'h0, vt[i].erv});
      if (vt[i].erv) chk($sformatf("v%0d rdata", i), bus.slave_readdata, vt[i].erd);
      chk($sformatf("v%0d cvalid", i), {63'h0, cmd_valid}, {63'h0, vt[i].ecv});
      chk($sformatf("v%0d cdata", i), cmd_data, vt[i].ecd);
    end

    // Idle cycle: readdata holds, no valid pulse.
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h000, 8'h00, Z, 1'b0);
    cycle();
    chk("hold rvalid", {63'h0, bus.slave_readdatavalid}, Z);
    chk("hold rdata", bus.slave_readdata, CD4);

    // Counter wrap 0xFFFFFFFF -> 0 on SNAP.
    @(negedge clk);
    force dut.snap_cnt_r = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 10'h008, 8'h01, 64'h1, 1'b0);
    #1;
    release dut.snap_cnt_r;
    cycle();
    @(negedge clk);
    drive(1'b0, 1'b1, 10'h008, 8'h00, Z, 1'b0);
    cycle();
    chk("wrap rdata", bus.slave_readdata, 64'h0000_0001_0000_0000);

    // Mid-operation reset with cmd_valid=1 and a read requested.
    @(negedge clk);
    reset = 1'b1;
    drive(1'b0, 1'b1, 10'h038, 8'h00, Z, 1'b0);
    cycle();
    chk("midrst rvalid", {63'h0, bus.slave_readdatavalid}, Z);
    chk("midrst rdata", bus.slave_readdata, Z);
    chk("midrst cvalid", {63'h0, cmd_valid}, Z);
    chk("midrst cdata", cmd_data, Z);
    @(negedge clk);
    reset = 1'b0;
    drive(1'b0, 1'b1, 10'h038, 8'h00, Z, 1'b0);
    cycle();
    chk("post-rst shadow rvalid", {63'h0, bus.slave_readdatavalid}, 64'h1);
    chk("post-rst shadow", bus.slave_readdata, Z);
    @(negedge clk);
    drive(1'b1, 1'b1, 10'h008, 8'h00, Z, 1'b0);
    cycle();
    chk("post-rst ctrl", bus.slave_readdata, Z);
    @(negedge clk);
    drive(1'b0, 1'b1, 10'h000, 8'h00, Z, 1'b0);
    cycle();
    chk("post-rst last_cmd", bus.slave_readdata, Z);
    @(negedge clk);
    drive(1'b0, 1'b0, 10'h000, 8'h00, Z, 1'b0);
    cycle();
    chk("post-rst idle rvalid", {63'h0, bus.slave_readdatavalid}, Z);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
